// File: rtl/amba_prot_axi_encoder.sv
// AMBA protection-bundle to AXI4 AxPROT/AxCACHE encoder.
// Requests are encoded on entry, held in a small FIFO and issued in order.
// Outstanding issued transactions are counted, and a fence keeps secure and
// non-secure traffic from being in flight together.
module amba_prot_axi_encoder #(
    parameter int ADDR_W  = 32,
    parameter int ID_W    = 4,
    parameter int DEPTH   = 2,
    parameter int MAX_OUT = 8
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [ADDR_W-1:0]            in_addr,
    input  logic [ID_W-1:0]              in_id,
    input  logic                         in_write,
    input  logic                         in_fetch,
    input  logic                         in_secure,
    input  logic                         in_privileged,
    input  logic                         in_writealloc,
    input  logic                         in_readalloc,
    input  logic                         in_modifiable,
    input  logic                         in_bufferable,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDR_W-1:0]            out_addr,
    output logic [ID_W-1:0]              out_id,
    output logic                         out_write,
    output logic [2:0]                   out_prot,
    output logic [3:0]                   out_cache,
    input  logic                         resp_valid,
    output logic [$clog2(MAX_OUT+1)-1:0] outstanding,
    output logic                         err
);
    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W  = $clog2(DEPTH + 1);
    localparam int OUT_W  = $clog2(MAX_OUT + 1);
    localparam int PEND_W = $clog2(DEPTH + MAX_OUT + 1);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic              write;
        logic [2:0]        prot;
        logic [3:0]        cache;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             ent_d;
    entry_t             head;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [OUT_W-1:0]   outstanding_q, outstanding_d;
    logic               last_secure_q, last_secure_d;
    logic               err_q, err_d;
    logic [PEND_W-1:0]  pending;
    logic               fence_stall, out_stall, push, pop, resp_ok;

    // Acceptance, handshakes and the encoded entry for the incoming request.
    always_comb begin
        pending     = PEND_W'(count_q) + PEND_W'(outstanding_q);
        fence_stall = (pending != '0) && (in_secure != last_secure_q);
        out_stall   = pending >= PEND_W'(MAX_OUT);
        in_ready    = (count_q < CNT_W'(DEPTH)) && !fence_stall && !out_stall;
        out_valid   = count_q != '0;
        push        = in_valid && in_ready;
        pop         = out_valid && out_ready;
        resp_ok     = resp_valid && (outstanding_q != '0);

        // fetch is dropped from prot[2] for writes; non-modifiable kills allocate hints
        ent_d.addr  = in_addr;
        ent_d.id    = in_id;
        ent_d.write = in_write;
        ent_d.prot  = {in_fetch & ~in_write, ~in_secure, in_privileged};
        ent_d.cache = {in_writealloc & in_modifiable, in_readalloc & in_modifiable,
                       in_modifiable, in_bufferable};
    end

    // Next-state for pointers, occupancy, outstanding count and flags.
    always_comb begin
        wr_ptr_d      = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d      = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d       = count_q;
        outstanding_d = outstanding_q;
        last_secure_d = push ? in_secure : last_secure_q;
        err_d         = err_q | (push & in_write & in_fetch)
                              | (resp_valid & (outstanding_q == '0));
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        case ({pop, resp_ok})
            2'b10:   outstanding_d = outstanding_q + 1'b1;
            2'b01:   outstanding_d = outstanding_q - 1'b1;
            default: outstanding_d = outstanding_q;
        endcase
    end

    // Control state; reset discards queued entries and the in-flight count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            outstanding_q <= '0;
            last_secure_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            outstanding_q <= outstanding_d;
            last_secure_q <= last_secure_d;
            err_q         <= err_d;
        end
    end

    // Entry storage; contents are only visible through the valid-gated mux.
    always_ff @(posedge clock) begin
        if (push) mem_q[wr_ptr_q] <= ent_d;
    end

    // Head-of-queue outputs, forced to zero while the FIFO is empty.
    always_comb begin
        head        = mem_q[rd_ptr_q];
        out_addr    = out_valid ? head.addr  : '0;
        out_id      = out_valid ? head.id    : '0;
        out_write   = out_valid ? head.write : 1'b0;
        out_prot    = out_valid ? head.prot  : 3'b000;
        out_cache   = out_valid ? head.cache : 4'b0000;
        outstanding = outstanding_q;
        err         = err_q;
    end
endmodule

// File: tb/tb_amba_prot_axi_encoder.sv
// Bench for amba_prot_axi_encoder: random requests against a queue-based
// reference model; a separate monitor pops expected entries on each issue.
module tb_amba_prot_axi_encoder;
    localparam int ADDR_W = 32, ID_W = 4, DEPTH = 2, MAX_OUT = 8;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    logic clock, reset;
    logic in_valid, in_ready, in_write, in_fetch, in_secure, in_privileged;
    logic in_writealloc, in_readalloc, in_modifiable, in_bufferable;
    logic [ADDR_W-1:0] in_addr, out_addr;
    logic [ID_W-1:0] in_id, out_id;
    logic out_valid, out_ready, out_write, resp_valid, err;
    logic [2:0] out_prot;
    logic [3:0] out_cache;
    logic [OUT_W-1:0] outstanding;

    amba_prot_axi_encoder #(.ADDR_W(ADDR_W), .ID_W(ID_W), .DEPTH(DEPTH), .MAX_OUT(MAX_OUT)) dut (
        .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_id(in_id), .in_write(in_write), .in_fetch(in_fetch),
        .in_secure(in_secure), .in_privileged(in_privileged), .in_writealloc(in_writealloc),
        .in_readalloc(in_readalloc), .in_modifiable(in_modifiable), .in_bufferable(in_bufferable),
        .out_valid(out_valid), .out_ready(out_ready), .out_addr(out_addr), .out_id(out_id),
        .out_write(out_write), .out_prot(out_prot), .out_cache(out_cache),
        .resp_valid(resp_valid), .outstanding(outstanding), .err(err));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [ID_W-1:0]   id;
        logic              write;
        int                prot;
        int                cache;
    } exp_t;

    exp_t sb[$];
    int   checks = 0, errors = 0;
    int   m_cnt = 0, m_out = 0;
    bit   m_last = 0, m_err = 0;
    bit   exp_rdy, pop_m, acc, resp_m;
    int   pend;
    exp_t e_new, e_got;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: occupancy, in-flight count, fence and error flag.
    always @(negedge clock) begin
        if (reset) begin
            m_cnt = 0; m_out = 0; m_last = 0; m_err = 0;
            sb.delete();
        end else begin
            pend    = m_cnt + m_out;
            exp_rdy = (m_cnt < DEPTH) && !(pend != 0 && in_secure != m_last) && (pend < MAX_OUT);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            chk("out_valid", 64'(out_valid), 64'(m_cnt != 0));
            chk("outstanding", 64'(outstanding), 64'(m_out));
            chk("err", 64'(err), 64'(m_err));
            pop_m  = (m_cnt != 0) && out_ready;
            acc    = in_valid && exp_rdy;
            resp_m = resp_valid && (m_out != 0);
            if (acc) begin
                e_new.addr  = in_addr;
                e_new.id    = in_id;
                e_new.write = in_write;
                e_new.prot  = (in_privileged ? 1 : 0) + (in_secure ? 0 : 2)
                            + ((in_fetch && !in_write) ? 4 : 0);
                e_new.cache = (in_bufferable ? 1 : 0)
                            + (in_modifiable ? 2 + (in_readalloc ? 4 : 0)
                                                 + (in_writealloc ? 8 : 0) : 0);
                sb.push_back(e_new);
                m_last = in_secure;
                if (in_write && in_fetch) m_err = 1;
            end
            if (resp_valid && m_out == 0) m_err = 1;
            m_out = m_out + (pop_m ? 1 : 0) - (resp_m ? 1 : 0);
            m_cnt = m_cnt + (acc ? 1 : 0) - (pop_m ? 1 : 0);
        end
    end

    // Monitor: every issued beat must match the oldest expected entry.
    always @(negedge clock) begin
        if (!reset) begin
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL issue_unexpected: got addr 0x%0h want no issue", out_addr);
                end else begin
                    e_got = sb.pop_front();
                    chk("out_addr", 64'(out_addr), 64'(e_got.addr));
                    chk("out_id", 64'(out_id), 64'(e_got.id));
                    chk("out_write", 64'(out_write), 64'(e_got.write));
                    chk("out_prot", 64'(out_prot), 64'(e_got.prot));
                    chk("out_cache", 64'(out_cache), 64'(e_got.cache));
                end
            end else if (!out_valid) begin
                chk("idle_outputs_zero", {20'd0, out_addr, out_id, out_write, out_prot, out_cache}, 64'd0);
            end
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic set_req(input logic [ADDR_W-1:0] a, input logic [ID_W-1:0] id,
                           input logic w, input logic f, input logic s, input logic p,
                           input logic wa, input logic ra, input logic m, input logic b);
        in_addr = a; in_id = id; in_write = w; in_fetch = f; in_secure = s;
        in_privileged = p; in_writealloc = wa; in_readalloc = ra;
        in_modifiable = m; in_bufferable = b;
    endtask

    task automatic rand_req(input int flip_pct);
        in_addr = $urandom; in_id = ID_W'($urandom);
        in_write = 1'($urandom);
        in_fetch = in_write ? ($urandom_range(0, 63) == 0) : 1'($urandom);
        if ($urandom_range(0, 99) < flip_pct) in_secure = ~in_secure;
        in_privileged = 1'($urandom); in_writealloc = 1'($urandom);
        in_readalloc = 1'($urandom); in_modifiable = 1'($urandom);
        in_bufferable = 1'($urandom);
    endtask

    // Queue two entries with outputs blocked, then reset between clock edges.
    task automatic async_reset_check();
        in_valid = 1'b1; out_ready = 1'b0; resp_valid = 1'b0;
        in_secure = m_last;
        repeat (3) step();
        in_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_out_valid", 64'(out_valid), 64'd0);
        chk("async_rst_outstanding", 64'(outstanding), 64'd0);
        chk("async_rst_err", 64'(err), 64'd0);
        repeat (2) step();
        reset = 1'b0;
    endtask

    int p_rdy[6]  = '{90, 15, 95, 50, 85, 5};
    int p_resp[6] = '{60, 50, 4, 30, 70, 20};
    int p_flip[6] = '{5, 10, 3, 20, 8, 5};

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; resp_valid = 1'b0;
        set_req('0, '0, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        step();

        // Secure privileged cacheable read: prot 001, cache 0110, one cycle later.
        set_req(32'h1000, 4'd3, 0, 0, 1, 1, 0, 1, 1, 0);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        chk("first_out_valid", 64'(out_valid), 64'd1);
        chk("first_out_prot", 64'(out_prot), 64'h1);
        chk("first_out_cache", 64'(out_cache), 64'h6);
        step();
        chk("first_outstanding", 64'(outstanding), 64'd1);
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        chk("first_resp_outstanding", 64'(outstanding), 64'd0);

        // Non-modifiable request keeps only the bufferable bit.
        set_req(32'h2000, 4'd5, 0, 0, 1, 0, 1, 1, 0, 1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("nonmod_cache", 64'(out_cache), 64'h1);
        step();

        // Instruction-fetch write: prot[2] cleared, err raised and sticky.
        set_req(32'h3000, 4'd7, 1, 1, 1, 0, 0, 0, 0, 0);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("fetch_write_prot", 64'(out_prot), 64'h0);
        chk("fetch_write_err", 64'(err), 64'd1);
        resp_valid = 1'b1;
        repeat (4) step();
        resp_valid = 1'b0;
        chk("err_sticky", 64'(err), 64'd1);

        reset = 1'b1;
        step();
        reset = 1'b0;
        // A response with nothing in flight is dropped and flags err.
        resp_valid = 1'b1;
        step();
        resp_valid = 1'b0;
        chk("stray_resp_err", 64'(err), 64'd1);
        chk("stray_resp_outstanding", 64'(outstanding), 64'd0);
        step();

        for (int ph = 0; ph < 6; ph++) begin
            for (int c = 0; c < 400; c++) begin
                in_valid   = ($urandom_range(0, 99) < 70);
                rand_req(p_flip[ph]);
                out_ready  = ($urandom_range(0, 99) < p_rdy[ph]);
                resp_valid = (m_out > 0 && $urandom_range(0, 99) < p_resp[ph])
                           || ($urandom_range(0, 999) == 0);
                step();
            end
            async_reset_check();
            step();
        end

        in_valid = 1'b0; out_ready = 1'b0; resp_valid = 1'b0;
        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/amba_prot_axi_encoder.md
Name: amba_prot_axi_encoder

Overview:
- Sits directly downstream of the AMBA protection-attribute bundle (fetch, secure, privileged, writealloc, readalloc, modifiable, bufferable).
- Accepts requests carrying those bits, buffers them in a small FIFO and encodes them into AXI4 AxPROT/AxCACHE for the master port.
- Tracks outstanding transactions and enforces a security-domain fence: no mixing of secure and non-secure traffic in flight.

Parameters:
- ADDR_W, 32, request address width
- ID_W, 4, transaction ID width
- DEPTH, 2, FIFO entries (power of two, >=2)
- MAX_OUT, 8, max outstanding issued transactions (>=1)

Ports:
- clock  in  1  sole clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&in_ready
- in_addr  in  ADDR_W  request address
- in_id  in  ID_W  request ID
- in_write  in  1  1=write, 0=read
- in_fetch, in_secure, in_privileged, in_writealloc, in_readalloc, in_modifiable, in_bufferable  in  1 each  protection bundle
- out_valid  out  1  encoded request valid
- out_ready  in  1  downstream accept
- out_addr  out  ADDR_W  address
- out_id  out  ID_W  ID
- out_write  out  1  direction
- out_prot  out  3  AxPROT
- out_cache  out  4  AxCACHE
- resp_valid  in  1  one pulse per completed transaction
- outstanding  out  $clog2(MAX_OUT+1)  issued, not yet completed
- err  out  1  sticky error flag

Behaviour:
- Interface: one clock; reset is asynchronous and active-high.
- Reset values: FIFO empty, out_valid=0, outstanding=0, err=0, last_secure=0. Data outputs are 0 while empty.
- Encoding is done at enqueue and stored per entry:
  - out_prot = {fetch & ~write, ~secure, privileged}
  - out_cache[0] = bufferable; out_cache[1] = modifiable
  - out_cache[2] = readalloc & modifiable; out_cache[3] = writealloc & modifiable (allocate bits forced 0 when non-modifiable)
- A write with fetch=1 is accepted with prot[2]=0 and sets err.
- Latency: an accept in cycle N gives out_valid=1 in cycle N+1 when the FIFO was empty. Pure FIFO ordering, no bypass.
- in_ready = (fifo_count<DEPTH) & ~fence_stall & ~out_stall, where:
  - pending = fifo_count + outstanding
  - fence_stall = (pending!=0) & (in_secure!=last_secure)
  - out_stall = pending>=MAX_OUT
  - in_ready does not depend on out_ready in the same cycle: a full FIFO accepts only after a pop.
- last_secure updates to in_secure on every accept.
- out_valid = fifo nonempty. out_* fields are stable while out_valid & ~out_ready.
- Pop on out_valid&out_ready; outstanding increments on pop and decrements on resp_valid. Pop and resp_valid in the same cycle leave it unchanged.
- resp_valid while outstanding==0 is ignored (counter stays 0) and sets err.
- Simultaneous push and pop: count unchanged; pointers wrap modulo DEPTH.
- err is sticky; only reset clears it.
- Reset mid-operation: all queued entries are discarded and outstanding returns to 0 immediately (asynchronous). No output pulses are generated.

Test Plan:
- Reset, then one read with addr=0x1000, id=3, secure=1, privileged=1, modifiable=1, readalloc=1 and out_ready=1 -> cycle+1: out_valid=1, out_prot=3'b001, out_cache=4'b0110. After the pop, outstanding=1; resp_valid drives outstanding to 0.
- out_ready=0, push 3 requests with DEPTH=2 -> in_ready=0 after the 2nd. Raise out_ready -> entries exit in order and the 3rd is accepted the cycle after the first pop.
- Secure read in flight (outstanding=1), then non-secure request -> in_ready=0 until resp_valid. Accepted the next cycle with out_prot[1]=1.
- modifiable=0, readalloc=1, writealloc=1, bufferable=1 -> out_cache=4'b0001. Write with fetch=1 -> out_prot[2]=0 and err=1, held until reset.
- MAX_OUT=8: issue 8 with no responses -> in_ready=0. A single resp_valid re-enables acceptance. A pop coinciding with resp_valid keeps outstanding constant.
- resp_valid with outstanding=0 -> outstanding stays 0, err=1. Asserting reset with 2 queued entries -> out_valid=0 and outstanding=0 asynchronously.
